// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch unit with redirect and flush
module fetch_unit #(
    parameter int                      DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] pc;
    logic                  capture;
    logic                  drop_hold;

    assign imem_addr = pc;

    // State register; reset lands in FETCH so the first request goes out right after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect outranks every other event in the same cycle
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (!redirect_valid && imem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    // A same-cycle response is the stale one, so nothing left to flush
                    state_next = imem_rsp_valid ? S_FETCH : S_FLUSH;
                end else if (imem_rsp_valid) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || instr_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_FLUSH: begin
                if (imem_rsp_valid) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Output decode: request strobe plus capture/release strobes for the datapath
    always_comb begin
        imem_req_valid = 1'b0;
        capture        = 1'b0;
        drop_hold      = 1'b0;
        case (state)
            S_FETCH: imem_req_valid = !redirect_valid && !rst;
            S_WAIT:  capture        = imem_rsp_valid && !redirect_valid;
            S_HOLD:  drop_hold      = redirect_valid || instr_ready;
            default: ;
        endcase
    end

    // Program counter: redirect target is forced word aligned, otherwise advance on capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
        end else if (capture) begin
            pc <= pc + DATA_WIDTH'(4);
        end
    end

    // Held instruction slot; contents only move on a capture, which cannot happen while valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (capture) begin
            instruction <= imem_rsp_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
        end else if (drop_hold) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven and scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_unit #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instruction   (instruction),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        instr_ready;
        logic        redirect_valid;
        logic [31:0] redirect_pc;
        logic        push;
        logic [31:0] push_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic        chk_instr;
        logic [31:0] exp_instr;
        logic [31:0] exp_ipc;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vectors = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   row       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic rq, input logic rv, input logic [31:0] rd,
                     input logic ir, input logic rdv, input logic [31:0] rpc,
                     input logic ps, input logic [31:0] ppc,
                     input logic er, input logic [31:0] ea, input logic eiv,
                     input logic ci, input logic [31:0] ei, input logic [31:0] eipc);
        vec_t t;
        t.rst = r; t.req_ready = rq; t.rsp_valid = rv; t.rsp_data = rd;
        t.instr_ready = ir; t.redirect_valid = rdv; t.redirect_pc = rpc;
        t.push = ps; t.push_pc = ppc;
        t.exp_req = er; t.exp_addr = ea; t.exp_iv = eiv;
        t.chk_instr = ci; t.exp_instr = ei; t.exp_ipc = eipc;
        vecs.push_back(t);
    endtask

    // A delivered instruction is one handed over without a same-cycle redirect
    task automatic monitor_handshake();
        sb_t e;
        if (instr_valid && instr_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected row %0d: got instr %h pc %h expected none", row, instruction, instr_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_instr", instruction, e.data);
                chk("sb_pc", instr_pc, e.pc);
            end
        end
    endtask

    initial begin
        int hs_cnt;
        int rsp_cnt;
        logic accept_pending;
        sb_t e;

        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        //  rst rq rv  rsp_data       ir rdv redirect_pc    ps push_pc        er ea             eiv ci instr          ipc
        v(1, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 1, 32'h0,         32'h0);
        v(0, 1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,         32'h0);
        v(0, 0, 1, 32'h0050_0093,  0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h0);
        v(0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0,         0, 32'h4,         1, 1, 32'h0050_0093, 32'h0);
        v(0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0,         1, 32'h4,         0, 0, 32'h0,         32'h0);
        v(0, 1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         1, 32'h4,         0, 0, 32'h0,         32'h0);
        v(0, 0, 1, 32'h1111_1111,  0, 0, 32'h0,         1, 32'h4,         0, 32'h4,         0, 0, 32'h0,         32'h0);
        for (int i = 0; i < 5; i++) begin
            v(0, 1, (i == 1), 32'hBAD0_0000, 0, 0, 32'h0, 0, 32'h0,  0, 32'h8,         1, 1, 32'h1111_1111, 32'h4);
        end
        v(0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0,         0, 32'h8,         1, 1, 32'h1111_1111, 32'h4);
        v(0, 1, 1, 32'hBAD1_1111,  1, 0, 32'h0,         0, 32'h0,         1, 32'h8,         0, 0, 32'h0,         32'h0);
        v(0, 0, 0, 32'h0,          0, 1, 32'h0000_0103, 0, 32'h0,         0, 32'h8,         0, 0, 32'h0,         32'h0);
        v(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         0, 32'h100,       0, 0, 32'h0,         32'h0);
        v(0, 0, 1, 32'hDEAD_BEEF,  0, 0, 32'h0,         0, 32'h0,         0, 32'h100,       0, 0, 32'h0,         32'h0);
        v(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         1, 32'h100,       0, 0, 32'h0,         32'h0);
        v(0, 1, 0, 32'h0,          0, 1, 32'h0000_0200, 0, 32'h0,         0, 32'h100,       0, 0, 32'h0,         32'h0);
        v(0, 1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         1, 32'h200,       0, 0, 32'h0,         32'h0);
        v(0, 0, 1, 32'h2222_2222,  0, 0, 32'h0,         0, 32'h0,         0, 32'h200,       0, 0, 32'h0,         32'h0);
        v(0, 0, 0, 32'h0,          1, 1, 32'h0000_0300, 0, 32'h0,         0, 32'h204,       1, 1, 32'h2222_2222, 32'h200);
        v(0, 1, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0,         1, 32'h300,       0, 0, 32'h0,         32'h0);
        v(0, 0, 1, 32'h3333_3333,  0, 1, 32'h0000_0400, 0, 32'h0,         0, 32'h300,       0, 0, 32'h0,         32'h0);
        v(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         1, 32'h400,       0, 0, 32'h0,         32'h0);
        v(0, 1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         1, 32'h400,       0, 0, 32'h0,         32'h0);
        v(0, 0, 0, 32'h0,          0, 1, 32'h0000_0500, 0, 32'h0,         0, 32'h400,       0, 0, 32'h0,         32'h0);
        v(0, 0, 0, 32'h0,          0, 1, 32'h0000_0600, 0, 32'h0,         0, 32'h500,       0, 0, 32'h0,         32'h0);
        v(0, 0, 1, 32'hBAD2_2222,  0, 1, 32'h0000_0700, 0, 32'h0,         0, 32'h600,       0, 0, 32'h0,         32'h0);
        v(0, 1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         1, 32'h700,       0, 0, 32'h0,         32'h0);
        v(0, 0, 0, 32'h0,          0, 1, 32'hFFFF_FFFF, 0, 32'h0,         0, 32'h700,       0, 0, 32'h0,         32'h0);
        v(0, 0, 1, 32'hBAD3_3333,  0, 0, 32'h0,         0, 32'h0,         0, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'h0);
        v(0, 1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'h0);
        v(0, 0, 1, 32'h4444_4444,  0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'h0);
        v(0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 1, 32'h4444_4444, 32'hFFFF_FFFC);
        v(0, 1, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,         32'h0);
        v(0, 0, 1, 32'h5555_5555,  0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h0);
        v(0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0,         0, 32'h4,         1, 1, 32'h5555_5555, 32'h0);
        v(0, 1, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0,         1, 32'h4,         0, 0, 32'h0,         32'h0);
        v(1, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 1, 32'h0,         32'h0);
        v(0, 0, 1, 32'h6666_6666,  0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,         32'h0);
        v(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,         32'h0);
        v(0, 1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 32'h0,         32'h0);
        v(0, 0, 1, 32'h7777_7777,  0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h0);
        v(0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0,         0, 32'h4,         1, 1, 32'h7777_7777, 32'h0);
        v(0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0,         1, 32'h4,         0, 0, 32'h0,         32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            row = i;
            @(negedge clk);
            rst            = vecs[i].rst;
            imem_req_ready = vecs[i].req_ready;
            imem_rsp_valid = vecs[i].rsp_valid;
            imem_rsp_data  = vecs[i].rsp_data;
            instr_ready    = vecs[i].instr_ready;
            redirect_valid = vecs[i].redirect_valid;
            redirect_pc    = vecs[i].redirect_pc;
            #1;
            n_vectors++;
            chk("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, vecs[i].exp_req});
            chk("imem_addr", imem_addr, vecs[i].exp_addr);
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, vecs[i].exp_iv});
            if (vecs[i].chk_instr) begin
                chk("instruction", instruction, vecs[i].exp_instr);
                chk("instr_pc", instr_pc, vecs[i].exp_ipc);
            end
            monitor_handshake();
            if (vecs[i].push) begin
                e.data = vecs[i].rsp_data;
                e.pc   = vecs[i].push_pc;
                sb.push_back(e);
            end
        end

        // Zero-wait memory with a consumer that never stalls: one instruction every 3 cycles
        hs_cnt         = 0;
        rsp_cnt        = 0;
        accept_pending = 1'b0;
        for (int c = 0; c < 12; c++) begin
            row = 1000 + c;
            @(negedge clk);
            rst            = 1'b0;
            redirect_valid = 1'b0;
            instr_ready    = 1'b1;
            imem_req_ready = 1'b1;
            imem_rsp_valid = accept_pending;
            imem_rsp_data  = 32'h0;
            if (accept_pending) begin
                imem_rsp_data = 32'hA000_0000 + 32'(rsp_cnt);
                e.data = imem_rsp_data;
                e.pc   = 32'h4 + 32'(4 * rsp_cnt);
                sb.push_back(e);
                rsp_cnt++;
            end
            #1;
            n_vectors++;
            if (instr_valid && instr_ready) hs_cnt++;
            monitor_handshake();
            accept_pending = imem_req_valid && imem_req_ready;
        end
        row = 2000;
        chk("throughput", 32'(hs_cnt), 32'd4);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
        $finish;
    end

endmodule
